// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage (IF, ID, EX, MEM, WB) pipeline
// without forwarding.
//
// In-flight register-file and SP writers are tracked in a shift-register
// scoreboard, one slot per stage between issue and write-back. A read-after-write
// dependence of the instruction in ID on any in-flight writer stalls IF/ID and
// inserts a bubble into ID/EX. A taken PC_load resolved in EX squashes the
// instruction in ID, and the wrong-path instructions behind it for FLUSH_CYCLES
// further cycles.
//
// Ports:
//   CLK, RSTN      clock (rising edge), asynchronous active-low reset
//   dec_*          decode-stage instruction: valid, sources A/B with use flags,
//                  register-file write flag and destination, SP access flag
//   ex_pc_load     taken PC_load resolved in EX this cycle
//   IF_EN, ID_EN   fetch/PC and decode register enables
//   ID_FLUSH       force a bubble into the decode-to-execute register
//   STALL          data-hazard stall active this cycle
//   STALL_CNT      saturating count of stall cycles
module pipeline_hazard_ctrl #(
    parameter int unsigned DEPTH        = 3,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             dec_valid,
    input  logic [2:0]       dec_srcA,
    input  logic             dec_useA,
    input  logic [2:0]       dec_srcB,
    input  logic             dec_useB,
    input  logic             dec_wren,
    input  logic [2:0]       dec_writeAd,
    input  logic             dec_spr,
    input  logic             ex_pc_load,
    output logic             IF_EN,
    output logic             ID_EN,
    output logic             ID_FLUSH,
    output logic             STALL,
    output logic [CNT_W-1:0] STALL_CNT
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [0:0] {
        StRun,
        StFlush
    } state_e;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    // Scoreboard: slot 0 is the instruction now in EX, slot DEPTH-1 the one in WB.
    logic [DEPTH-1:0]  sb_v_q;
    logic [DEPTH-1:0]  sb_wr_q;
    logic [DEPTH-1:0]  sb_spr_q;
    logic [2:0]        sb_addr_q [DEPTH];

    logic hazard_raw;
    logic hazard;
    logic issue;
    logic if_en, id_en, id_flush, stall;

    // The WB slot still counts: the register-file write lands at the end of WB.
    always_comb begin
        hazard_raw = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (sb_v_q[i]) begin
                if (sb_wr_q[i] && dec_useA && (sb_addr_q[i] == dec_srcA)) hazard_raw = 1'b1;
                if (sb_wr_q[i] && dec_useB && (sb_addr_q[i] == dec_srcB)) hazard_raw = 1'b1;
                if (sb_spr_q[i] && dec_spr) hazard_raw = 1'b1;
            end
        end
        hazard = dec_valid & hazard_raw;
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        if_en    = 1'b1;
        id_en    = 1'b1;
        id_flush = 1'b0;
        stall    = 1'b0;
        issue    = 1'b0;
        if (ex_pc_load) begin
            // Squash wins over everything, including a pending data hazard.
            id_flush = 1'b1;
            if (FLUSH_CYCLES != 0) begin
                state_d = StFlush;
                fcnt_d  = FC_W'(FLUSH_CYCLES);
            end else begin
                state_d = StRun;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hazard) begin
                        if_en    = 1'b0;
                        id_en    = 1'b0;
                        id_flush = 1'b1;
                        stall    = 1'b1;
                    end else begin
                        issue = dec_valid;
                    end
                end
                StFlush: begin
                    id_flush = 1'b1;
                    if (fcnt_q <= FC_W'(1)) begin
                        state_d = StRun;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - FC_W'(1);
                    end
                end
                default: begin
                    state_d = StRun;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= StRun;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sb_v_q   <= '0;
            sb_wr_q  <= '0;
            sb_spr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                sb_addr_q[i] <= 3'd0;
            end
        end else begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                sb_v_q[i]    <= sb_v_q[i-1];
                sb_wr_q[i]   <= sb_wr_q[i-1];
                sb_spr_q[i]  <= sb_spr_q[i-1];
                sb_addr_q[i] <= sb_addr_q[i-1];
            end
            // Non-writers and bubbles enter as invalid entries.
            sb_v_q[0]    <= issue & (dec_wren | dec_spr);
            sb_wr_q[0]   <= issue & dec_wren;
            sb_spr_q[0]  <= issue & dec_spr;
            sb_addr_q[0] <= issue ? dec_writeAd : 3'd0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // While in reset the pipeline front end is frozen and ID/EX held empty.
    always_comb begin
        if (!RSTN) begin
            IF_EN    = 1'b0;
            ID_EN    = 1'b0;
            ID_FLUSH = 1'b1;
            STALL    = 1'b0;
        end else begin
            IF_EN    = if_en;
            ID_EN    = id_en;
            ID_FLUSH = id_flush;
            STALL    = stall;
        end
    end

    assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model that
// tracks, per register and for SP, the first cycle at which a read is safe.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned DEPTH        = 3;
    localparam int unsigned FLUSH_CYCLES = 1;
    localparam int unsigned CNT_W        = 16;

    logic             CLK = 1'b0;
    logic             RSTN = 1'b0;
    logic             dec_valid = 1'b0;
    logic [2:0]       dec_srcA = 3'd0;
    logic             dec_useA = 1'b0;
    logic [2:0]       dec_srcB = 3'd0;
    logic             dec_useB = 1'b0;
    logic             dec_wren = 1'b0;
    logic [2:0]       dec_writeAd = 3'd0;
    logic             dec_spr = 1'b0;
    logic             ex_pc_load = 1'b0;
    logic             IF_EN, ID_EN, ID_FLUSH, STALL;
    logic [CNT_W-1:0] STALL_CNT;

    pipeline_hazard_ctrl #(
        .DEPTH       (DEPTH),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .dec_valid  (dec_valid),
        .dec_srcA   (dec_srcA),
        .dec_useA   (dec_useA),
        .dec_srcB   (dec_srcB),
        .dec_useB   (dec_useB),
        .dec_wren   (dec_wren),
        .dec_writeAd(dec_writeAd),
        .dec_spr    (dec_spr),
        .ex_pc_load (ex_pc_load),
        .IF_EN      (IF_EN),
        .ID_EN      (ID_EN),
        .ID_FLUSH   (ID_FLUSH),
        .STALL      (STALL),
        .STALL_CNT  (STALL_CNT)
    );

    initial forever #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit run_chk = 1'b0;
    logic rst_drive = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // ready[r]: first cycle number at which reading r is hazard-free.
    int unsigned cyc = 1;
    int unsigned ready [8];
    int unsigned sp_ready = 0;
    int unsigned flush_left = 0;
    int unsigned stall_cnt_m = 0;

    initial for (int r = 0; r < 8; r++) ready[r] = 0;

    task automatic model_out(output logic e_if, output logic e_id, output logic e_fl,
                             output logic e_st, output logic e_issue);
        logic hz;
        hz = dec_valid && ((dec_useA && cyc < ready[dec_srcA]) ||
                           (dec_useB && cyc < ready[dec_srcB]) ||
                           (dec_spr && cyc < sp_ready));
        e_issue = 1'b0;
        if (!RSTN) begin
            e_if = 0; e_id = 0; e_fl = 1; e_st = 0;
        end else if (ex_pc_load || flush_left > 0) begin
            e_if = 1; e_id = 1; e_fl = 1; e_st = 0;
        end else if (hz) begin
            e_if = 0; e_id = 0; e_fl = 1; e_st = 1;
        end else begin
            e_if = 1; e_id = 1; e_fl = 0; e_st = 0;
            e_issue = dec_valid;
        end
    endtask

    always @(posedge CLK or negedge RSTN) begin
        logic e_if, e_id, e_fl, e_st, e_issue;
        if (!RSTN) begin
            for (int r = 0; r < 8; r++) ready[r] = 0;
            sp_ready    = 0;
            flush_left  = 0;
            stall_cnt_m = 0;
        end else begin
            model_out(e_if, e_id, e_fl, e_st, e_issue);
            // Issued in cycle c: visible in the register file from cycle c+DEPTH+1.
            if (e_issue && dec_wren) ready[dec_writeAd] = cyc + DEPTH + 1;
            if (e_issue && dec_spr) sp_ready = cyc + DEPTH + 1;
            if (e_st && stall_cnt_m < (2 ** CNT_W) - 1) stall_cnt_m++;
            if (ex_pc_load) flush_left = FLUSH_CYCLES;
            else if (flush_left > 0) flush_left--;
            cyc++;
        end
    end

    always @(negedge CLK) begin
        logic e_if, e_id, e_fl, e_st, e_issue;
        if (run_chk) begin
            model_out(e_if, e_id, e_fl, e_st, e_issue);
            check("IF_EN", {31'd0, IF_EN}, {31'd0, e_if});
            check("ID_EN", {31'd0, ID_EN}, {31'd0, e_id});
            check("ID_FLUSH", {31'd0, ID_FLUSH}, {31'd0, e_fl});
            check("STALL", {31'd0, STALL}, {31'd0, e_st});
            check("STALL_CNT", {16'd0, STALL_CNT}, stall_cnt_m);
        end
    end

    // ---------------- stimulus ----------------
    // One cycle: clock the previous inputs, drive new ones, return at the negedge.
    task automatic step(input logic v, input logic [2:0] a, input logic ua,
                        input logic [2:0] b, input logic ub, input logic w,
                        input logic [2:0] wa, input logic s, input logic pcl);
        @(posedge CLK);
        #1;
        RSTN = rst_drive;
        dec_valid = v; dec_srcA = a; dec_useA = ua; dec_srcB = b; dec_useB = ub;
        dec_wren = w; dec_writeAd = wa; dec_spr = s; ex_pc_load = pcl;
        @(negedge CLK);
    endtask

    task automatic nop();
        step(0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0);
    endtask

    task automatic wr(input logic [2:0] wa);
        step(1, 3'd0, 0, 3'd0, 0, 1, wa, 0, 0);
    endtask

    // Hold one instruction in ID until it issues; return the stall cycles seen.
    task automatic hold(input string name, input logic [2:0] a, input logic ua,
                        input logic [2:0] b, input logic ub, input logic s, input int exp);
        int n;
        n = 0;
        step(1, a, ua, b, ub, 0, 3'd0, s, 0);
        while (STALL === 1'b1 && n < 20) begin
            n++;
            step(1, a, ua, b, ub, 0, 3'd0, s, 0);
        end
        if (n >= 20) $display("FAIL %s_timeout: got %0d stall cycles, expected %0d", name, n, exp);
        check(name, n, exp);
    endtask

    initial begin
        int base;
        int en_cnt;
        run_chk = 1'b1;
        rst_drive = 1'b0;
        nop();
        check("rst_IF_EN", {31'd0, IF_EN}, 0);
        check("rst_ID_FLUSH", {31'd0, ID_FLUSH}, 1);
        check("rst_STALL_CNT", {16'd0, STALL_CNT}, 0);
        nop();
        rst_drive = 1'b1;
        nop();

        // Independent writers.
        en_cnt = 0;
        wr(3'd1); en_cnt += int'(IF_EN & ID_EN);
        wr(3'd2); en_cnt += int'(IF_EN & ID_EN);
        wr(3'd3); en_cnt += int'(IF_EN & ID_EN);
        check("indep_enables", en_cnt, 3);
        check("indep_stall_cnt", {16'd0, STALL_CNT}, 0);
        repeat (3) nop();

        // RAW on the immediately preceding writer.
        base = int'(STALL_CNT);
        wr(3'd2);
        hold("raw_next_stalls", 3'd2, 1, 3'd0, 0, 0, 3);
        check("raw_next_cnt", int'(STALL_CNT) - base, 3);
        repeat (3) nop();

        // RAW with one instruction in between, on source B; then unused source B.
        wr(3'd5);
        wr(3'd1);
        hold("raw_gap_srcB", 3'd0, 0, 3'd5, 1, 0, 2);
        wr(3'd5);
        hold("srcB_unused", 3'd0, 0, 3'd5, 0, 0, 0);
        repeat (3) nop();

        // SP push then pop; then SP ops separated by three independent instructions.
        step(1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 1, 0);
        hold("sp_back2back", 3'd0, 0, 3'd0, 0, 1, 3);
        repeat (3) nop();
        step(1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 1, 0);
        wr(3'd1); wr(3'd2); wr(3'd3);
        hold("sp_separated", 3'd0, 0, 3'd0, 0, 1, 0);
        repeat (3) nop();

        // Same register on both sources.
        base = int'(STALL_CNT);
        wr(3'd6);
        hold("same_src_AB", 3'd6, 1, 3'd6, 1, 0, 3);
        check("same_src_cnt", int'(STALL_CNT) - base, 3);
        repeat (3) nop();

        // Taken PC_load during a stall; the squashed writer of r6 must not enter.
        wr(3'd4);
        step(1, 3'd4, 1, 3'd0, 0, 0, 3'd0, 0, 0);
        check("pcl_pre_stall", {31'd0, STALL}, 1);
        step(1, 3'd4, 1, 3'd0, 0, 1, 3'd6, 0, 1);
        check("pcl_STALL", {31'd0, STALL}, 0);
        check("pcl_IF_EN", {31'd0, IF_EN}, 1);
        check("pcl_ID_EN", {31'd0, ID_EN}, 1);
        check("pcl_ID_FLUSH", {31'd0, ID_FLUSH}, 1);
        step(1, 3'd7, 1, 3'd0, 0, 1, 3'd6, 0, 0);
        check("flush_ID_FLUSH", {31'd0, ID_FLUSH}, 1);
        check("flush_STALL", {31'd0, STALL}, 0);
        step(1, 3'd6, 1, 3'd0, 0, 0, 3'd0, 0, 0);
        check("post_flush_ID_FLUSH", {31'd0, ID_FLUSH}, 0);
        check("post_flush_STALL", {31'd0, STALL}, 0);
        repeat (3) nop();

        // Reset in the middle of FLUSH with r1/r2 still in flight.
        wr(3'd1);
        wr(3'd2);
        step(0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1);
        rst_drive = 1'b0;
        nop();
        check("midflush_rst_IF_EN", {31'd0, IF_EN}, 0);
        check("midflush_rst_STALL", {31'd0, STALL}, 0);
        rst_drive = 1'b1;
        step(1, 3'd2, 1, 3'd1, 1, 0, 3'd0, 0, 0);
        check("after_rst_STALL", {31'd0, STALL}, 0);
        check("after_rst_ID_FLUSH", {31'd0, ID_FLUSH}, 0);
        check("after_rst_STALL_CNT", {16'd0, STALL_CNT}, 0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            rst_drive = ($urandom_range(0, 249) != 0);
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
        end

        @(posedge CLK);
        #1;
        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It tracks in-flight register-file and stack-pointer writers in a scoreboard and detects read-after-write hazards against the instruction in ID. It drives the enables and flush of the fetch/decode registers and the bubble-insert into the decode-to-execute register. It also squashes wrong-path instructions after a taken PC_load resolves in EX. The pipeline has no forwarding: every hazard is resolved by stalling.

Parameters:
DEPTH, 3, scoreboard slots (EX, MEM, WB) before a result is visible in the register file
FLUSH_CYCLES, 1, extra bubble cycles after the branch cycle (IF-register wrong-path depth)
CNT_W, 16, width of the stall performance counter

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  asynchronous active-low reset
dec_valid  in  1  ID holds a valid instruction
dec_srcA  in  3  source register A address
dec_useA  in  1  source A is read
dec_srcB  in  3  source register B address
dec_useB  in  1  source B is read
dec_wren  in  1  instruction writes the register file
dec_writeAd  in  3  destination register
dec_spr  in  1  instruction uses or modifies SP (SPR_w, SPR_i or SPR_d)
ex_pc_load  in  1  taken PC_load resolved in EX this cycle
IF_EN  out  1  fetch register and PC enable
ID_EN  out  1  decode register enable
ID_FLUSH  out  1  force bubble into the decode-to-execute register (wren, write, PC_load, SPR_* = 0)
STALL  out  1  data-hazard stall active this cycle
STALL_CNT  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard: DEPTH slots of {v, addr[2:0], spr}. Every cycle, slot[i+1] <= slot[i]. Slot[DEPTH-1] retires.
- Slot[0] <= {1, dec_writeAd, dec_spr} on issue. Otherwise slot[0] <= 0 (bubble).
- v is set only when dec_wren or dec_spr is high. An instruction with neither flag issues as v = 0.
- Hazard (combinational): dec_valid AND any of:
  - a valid slot with addr == dec_srcA and dec_useA
  - a valid slot with addr == dec_srcB and dec_useB
  - dec_spr and a valid slot with spr = 1
- Address match counts only for slots whose entry came from dec_wren. Each slot also stores a wr bit for this purpose.
- FSM states: RUN, FLUSH. Reset state is RUN, with flush counter = 0.
- RUN, no ex_pc_load, no hazard: IF_EN = 1, ID_EN = 1, ID_FLUSH = 0, STALL = 0. Issue = dec_valid.
- RUN, hazard, no ex_pc_load: IF_EN = 0, ID_EN = 0, ID_FLUSH = 1, STALL = 1. No issue. The scoreboard still shifts, so the hazard clears after at most DEPTH cycles.
- ex_pc_load in any state (highest priority):
  - IF_EN = 1, ID_EN = 1, ID_FLUSH = 1, STALL = 0; no issue
  - next state FLUSH, with counter loaded to FLUSH_CYCLES
  - if FLUSH_CYCLES = 0, stay in RUN
- FLUSH: IF_EN = 1, ID_EN = 1, ID_FLUSH = 1, no issue, hazard ignored. The counter decrements; on reaching 1 → RUN. A new ex_pc_load reloads the counter.
- STALL_CNT increments in every cycle with STALL = 1 and saturates at all-ones. It is never cleared except by reset.
- Outputs are combinational from state, scoreboard and inputs; the scoreboard, FSM and counter are registered.
- Reset, including mid-stall or mid-flush: scoreboard cleared, state RUN, STALL_CNT = 0. While RSTN = 0: IF_EN = 0, ID_EN = 0, ID_FLUSH = 1, STALL = 0.
- Same-cycle retire and match: slot[DEPTH-1] still counts as a hazard in its last cycle, because the register-file write lands at the end of WB.
- dec_srcA = dec_srcB = the same address is legal and yields a single hazard.
- dec_valid = 0 never causes a hazard or an issue.

Test Plan:
- Reset, then independent stream (writes to r1, r2, r3 with no dependences) → IF_EN = ID_EN = 1 every cycle, STALL never set, STALL_CNT = 0.
- Issue write r2, then next cycle read r2 (useA) → STALL = 1 for exactly 3 cycles, ID_FLUSH = 1 on those cycles, issue on the 4th, STALL_CNT = 3.
- Write r5, one independent instruction, then read r5 on srcB → 2 stall cycles. Read with useB = 0 → 0 stalls.
- SP push (dec_spr) followed by SP pop → 3 stall cycles. Two SP ops separated by 3 independent instructions → 0 stalls.
- ex_pc_load asserted during a hazard stall → that cycle STALL = 0 and IF_EN = ID_EN = ID_FLUSH = 1. The next cycle is in FLUSH (ID_FLUSH = 1), then RUN. No wrong-path entry appears in the scoreboard.
- Pull RSTN low mid-FLUSH with 2 valid slots, then release → first cycle after release in RUN. A read of a previously pending register issues with no stall. STALL_CNT = 0.
